// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int unsigned PRESC_8  = 8;
    localparam int unsigned PRESC_16 = 16;
    localparam int unsigned PRESC_32 = 32;

    // The sampler votes on edges P/2-1..P/2+1, so its result settles two edges past P/2.
    localparam int unsigned MID_OFFSET = 2;

    function automatic int unsigned mid_edge(input int unsigned presc);
        return (presc / 2) + MID_OFFSET;
    endfunction

endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// Oversample edge counter with per-bit wrap and frame bit index.
module edge_bit_counter #(
    parameter int PRESC_W = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               en,
    input  logic               clr,
    input  logic [PRESC_W-1:0] presc,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               last_edge
);

    assign last_edge = (edge_cnt == (presc - PRESC_W'(1)));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clr) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (en) begin
            if (last_edge) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + 4'd1;
            end else begin
                edge_cnt <= edge_cnt + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART RX frame sequencer: start detect, per-phase check/shift pulses and the final data_valid.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic               strt_glitch,
    input  logic               par_err,
    input  logic               stp_err,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [3:0]         bit_cnt,
    output logic               dat_samp_en,
    output logic               strt_chk_en,
    output logic               deser_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               data_valid,
    output rx_state_e          state_dbg
);

    rx_state_e          state;
    logic [PRESC_W-1:0] presc_l;
    logic               par_en_l;
    logic               frame_err;
    logic               last_edge;
    logic               cnt_en;
    logic               cnt_clr;
    logic [PRESC_W-1:0] pre_mid_edge;
    logic               pre_mid;

    assign state_dbg = state;

    // Pulses are registered, so they are launched one edge before the mid-bit point.
    assign pre_mid_edge = PRESC_W'(mid_edge(32'(presc_l)) - 1);
    assign pre_mid      = (edge_cnt == pre_mid_edge);

    // Counters restart whenever the frame ends or restarts, so every START begins at edge 0.
    assign cnt_en  = (state != ST_IDLE);
    assign cnt_clr = (state == ST_IDLE) ||
                     (last_edge && (((state == ST_START) && strt_glitch) || (state == ST_STOP)));

    edge_bit_counter #(.PRESC_W(PRESC_W)) u_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .en        (cnt_en),
        .clr       (cnt_clr),
        .presc     (presc_l),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .last_edge (last_edge)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= ST_IDLE;
            presc_l     <= PRESC_W'(PRESC_8);
            par_en_l    <= 1'b0;
            frame_err   <= 1'b0;
            dat_samp_en <= 1'b0;
            strt_chk_en <= 1'b0;
            deser_en    <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;
        end else begin
            strt_chk_en <= 1'b0;
            deser_en    <= 1'b0;
            par_chk_en  <= 1'b0;
            stp_chk_en  <= 1'b0;
            data_valid  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!RX_IN) begin
                        state       <= ST_START;
                        presc_l     <= Prescale;
                        par_en_l    <= PAR_EN;
                        frame_err   <= 1'b0;
                        dat_samp_en <= 1'b1;
                    end
                end
                ST_START: begin
                    strt_chk_en <= pre_mid;
                    if (last_edge) begin
                        if (strt_glitch) begin
                            state       <= ST_IDLE;
                            dat_samp_en <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    deser_en <= pre_mid;
                    if (last_edge && (bit_cnt == 4'(DATA_WIDTH))) begin
                        state <= par_en_l ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    par_chk_en <= pre_mid;
                    if (last_edge) begin
                        frame_err <= par_err;
                        state     <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    stp_chk_en <= pre_mid;
                    if (last_edge) begin
                        data_valid <= !frame_err && !stp_err;
                        // A low line here is the next frame's start bit.
                        if (!RX_IN) begin
                            state     <= ST_START;
                            presc_l   <= Prescale;
                            par_en_l  <= PAR_EN;
                            frame_err <= 1'b0;
                        end else begin
                            state       <= ST_IDLE;
                            dat_samp_en <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    dat_samp_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
